// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//
// Execute-stage controller for the shared 8-bit combinational ALU. Accepts one
// operation at a time on a valid/ready request channel, drives the ALU operand
// and opcode lines, captures the result and the architectural {N,Z,C,V} flag
// register, and returns the result on a valid/ready response channel.
// An 8x8 unsigned multiply is performed by iterating the ALU's ADD once per
// multiplier bit (shift-add).
//
// Build option:
//   SEQ_MUL_EN  defined   -> multi-cycle MUL datapath (op 6) is built.
//               undefined -> no multiply datapath; op 6 is passed to the ALU
//                            as a plain single-cycle operation.
//
// Parameters:
//   MUL_STEPS      shift-add iterations for MUL; equals the operand width.
//
// Ports:
//   clk, rst       clock (rising edge), synchronous active-high reset
//   req_valid/req_ready/req_op/req_a/req_b   request channel
//                  op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 MUL, 7 CMP
//   resp_valid/resp_ready/resp_lo/resp_hi    response channel
//   flags          architectural flag register {N,Z,C,V}
//   alu_a/alu_b/alu_op                       drive to the ALU
//   alu_result/alu_zero/alu_negative/alu_carry/alu_overflow   from the ALU
// -----------------------------------------------------------------------------
module alu_sequencer #(
    parameter int MUL_STEPS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_op,
    input  logic [MUL_STEPS-1:0] req_a,
    input  logic [MUL_STEPS-1:0] req_b,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [MUL_STEPS-1:0] resp_lo,
    output logic [MUL_STEPS-1:0] resp_hi,
    output logic [3:0]           flags,
    output logic [MUL_STEPS-1:0] alu_a,
    output logic [MUL_STEPS-1:0] alu_b,
    output logic [2:0]           alu_op,
    input  logic [MUL_STEPS-1:0] alu_result,
    input  logic                 alu_zero,
    input  logic                 alu_negative,
    input  logic                 alu_carry,
    input  logic                 alu_overflow
);

    localparam int W = MUL_STEPS;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_CMP = 3'd7;

`ifdef SEQ_MUL_EN
    localparam logic [2:0] OP_MUL = 3'd6;
    localparam int         CW     = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, MUL_STEP, RESP} state_t;
`else
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
`endif

    state_t         state;
    logic [2:0]     op_q;
    logic [W-1:0]   a_q;        // operand A; also the multiplicand during MUL
    logic [W-1:0]   b_q;

`ifdef SEQ_MUL_EN
    logic [W-1:0]   acc_hi;     // partial product, upper half
    logic [W-1:0]   acc_lo;     // remaining multiplier bits / product lower half
    logic [CW-1:0]  count;
    logic           step_c;
    logic [W-1:0]   step_s;
    logic [2*W-1:0] product;    // accumulator value after this cycle's step

    // One shift-add step: add the multiplicand only when the current
    // multiplier bit is set, then shift the 2W+1-bit {carry,sum,acc_lo} right.
    // NOTE: every always_comb output gets a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        step_c = 1'b0;
        step_s = acc_hi;
        if (acc_lo[0]) begin
            step_c = alu_carry;
            step_s = alu_result;
        end
        product = {step_c, step_s, acc_lo[W-1:1]};
    end
`endif

    // ALU drive is combinational from state and latched operands so the ALU
    // result is usable in the same cycle; idle states park the lines at zero.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = OP_ADD;
        case (state)
            EXEC: begin
                alu_a  = a_q;
                alu_b  = b_q;
                alu_op = (op_q == OP_CMP) ? OP_SUB : op_q;
            end
`ifdef SEQ_MUL_EN
            MUL_STEP: begin
                alu_a  = acc_hi;
                alu_b  = a_q;
                alu_op = OP_ADD;
            end
`endif
            default: ;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: operand and accumulator registers are reset as well; they
            // are few, and it keeps the ALU lines and outputs defined from the
            // very first cycle.
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_lo    <= '0;
            resp_hi    <= '0;
            flags      <= 4'b0000;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
`ifdef SEQ_MUL_EN
            acc_hi     <= '0;
            acc_lo     <= '0;
            count      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // req_ready is high throughout IDLE
                    if (req_valid) begin
                        op_q      <= req_op;
                        a_q       <= req_a;
                        b_q       <= req_b;
                        req_ready <= 1'b0;
`ifdef SEQ_MUL_EN
                        if (req_op == OP_MUL) begin
                            acc_hi <= '0;
                            acc_lo <= req_b;
                            count  <= '0;
                            state  <= MUL_STEP;
                        end else begin
                            state  <= EXEC;
                        end
`else
                        state     <= EXEC;
`endif
                    end
                end

                EXEC: begin
                    // CMP sets flags like SUB but returns operand A unchanged
                    resp_lo    <= (op_q == OP_CMP) ? a_q : alu_result;
                    resp_hi    <= '0;
                    flags      <= {alu_negative, alu_zero, alu_carry, alu_overflow};
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end

`ifdef SEQ_MUL_EN
                MUL_STEP: begin
                    {acc_hi, acc_lo} <= product;
                    count            <= count + 1'b1;
                    // The last step's product goes straight to the response
                    // registers so RESP follows without an extra cycle.
                    if (count == CW'(W - 1)) begin
                        resp_lo    <= product[W-1:0];
                        resp_hi    <= product[2*W-1:W];
                        flags      <= {product[2*W-1], product == '0,
                                       product[2*W-1:W] != '0, 1'b0};
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
`endif

                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
//
// Self-checking bench for alu_sequencer. Contains a combinational model of the
// shared ALU (bit-level), a table of directed vectors, hand-written sequences
// for backpressure and reset-in-flight, and randomized operations checked
// against an arithmetic reference model. Honours SEQ_MUL_EN like the design.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;

    localparam int MUL_STEPS = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic       resp_valid;
    logic       resp_ready;
    logic [7:0] resp_lo;
    logic [7:0] resp_hi;
    logic [3:0] flags;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       alu_negative;
    logic       alu_carry;
    logic       alu_overflow;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.MUL_STEPS(MUL_STEPS)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_lo      (resp_lo),
        .resp_hi      (resp_hi),
        .flags        (flags),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_negative (alu_negative),
        .alu_carry    (alu_carry),
        .alu_overflow (alu_overflow)
    );

    // ---------------- shared ALU model (bit-level) ----------------
    logic [8:0] alu_t;
    always_comb begin
        alu_t        = '0;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        case (alu_op)
            3'd0: begin
                alu_t        = {1'b0, alu_a} + {1'b0, alu_b};
                alu_carry    = alu_t[8];
                alu_overflow = (alu_a[7] == alu_b[7]) && (alu_t[7] != alu_a[7]);
            end
            3'd1: begin
                alu_t        = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
                alu_carry    = alu_t[8];
                alu_overflow = (alu_a[7] != alu_b[7]) && (alu_t[7] != alu_a[7]);
            end
            3'd2:    alu_t = {1'b0, alu_a & alu_b};
            3'd3:    alu_t = {1'b0, alu_a | alu_b};
            3'd4:    alu_t = {1'b0, alu_a ^ alu_b};
            3'd5:    alu_t = {1'b0, ~alu_a};
            default: alu_t = '0;
        endcase
    end
    assign alu_result   = alu_t[7:0];
    assign alu_zero     = (alu_t[7:0] == 8'h00);
    assign alu_negative = alu_t[7];

    // ---------------- reference model (arithmetic) ----------------
    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] lo;
        logic [7:0] hi;
        logic [3:0] fl;
        int         cycles;
    } vec_t;

    function automatic vec_t ref_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        vec_t x;
        int ua = a;
        int ub = b;
        int sa = $signed(a);
        int sb = $signed(b);
        int r  = 0;
        int sr = 0;
        int p;
        logic c = 1'b0;
        logic v = 1'b0;
        logic [7:0] r8;
        x.op = op; x.a = a; x.b = b; x.hi = 8'h00; x.cycles = 2;
        case (op)
            3'd0: begin r = ua + ub; sr = sa + sb; c = (r > 255); v = (sr > 127 || sr < -128); end
            3'd1,
            3'd7: begin r = ua - ub; sr = sa - sb; c = (ua >= ub); v = (sr > 127 || sr < -128); end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ua ^ ub;
            3'd5: r = 255 - ua;
            default: r = 0;
        endcase
        r8   = r[7:0];
        x.lo = (op == 3'd7) ? a : r8;
        x.fl = {r8[7], r8 == 8'h00, c, v};
`ifdef SEQ_MUL_EN
        if (op == 3'd6) begin
            p        = ua * ub;
            x.lo     = p[7:0];
            x.hi     = p[15:8];
            x.fl     = {p >= 32768, p == 0, p > 255, 1'b0};
            x.cycles = MUL_STEPS + 1;
        end
`else
        p = 0;
        if (op == 3'd6) x.fl = 4'b0100;
`endif
        return x;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Waits (bounded) at falling edges for resp_valid; returns edges waited.
    task automatic wait_resp(output int edges);
        edges = 0;
        @(negedge clk);
        while (!resp_valid && edges < 40) begin
            @(negedge clk);
            edges++;
        end
    endtask

    // Issues one request with resp_ready=1 and returns the response fields.
    // cycles counts from the accept cycle (cycle 0) to the first resp_valid.
    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] lo, output logic [7:0] hi,
                          output logic [3:0] fl, output int cycles);
        int guard = 0;
        int edges;
        resp_ready = 1'b1;
        @(negedge clk);
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        while (!req_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_resp(edges);
        cycles = edges + 1;
        lo = resp_lo; hi = resp_hi; fl = flags;
        @(posedge clk);
    endtask

    task automatic run_and_check(input string tag, input vec_t v);
        logic [7:0] lo, hi;
        logic [3:0] fl;
        int cyc;
        run_op(v.op, v.a, v.b, lo, hi, fl, cyc);
        check({tag, "_lo"},     {24'h0, lo}, {24'h0, v.lo});
        check({tag, "_hi"},     {24'h0, hi}, {24'h0, v.hi});
        check({tag, "_flags"},  {28'h0, fl}, {28'h0, v.fl});
        check({tag, "_cycles"}, cyc,         v.cycles);
    endtask

    // ---------------- test ----------------
    vec_t vecs[$];

    initial begin
        int edges;
        logic [3:0] last_fl;

        // Directed table: {op, a, b, lo, hi, flags NZCV, cycles}
        vecs.push_back('{op:3'd0, a:8'h7F, b:8'h01, lo:8'h80, hi:8'h00, fl:4'b1001, cycles:2});
        vecs.push_back('{op:3'd7, a:8'h05, b:8'h05, lo:8'h05, hi:8'h00, fl:4'b0110, cycles:2});
        vecs.push_back('{op:3'd0, a:8'h01, b:8'h01, lo:8'h02, hi:8'h00, fl:4'b0000, cycles:2});
        vecs.push_back('{op:3'd1, a:8'h03, b:8'h05, lo:8'hFE, hi:8'h00, fl:4'b1000, cycles:2});
        vecs.push_back('{op:3'd1, a:8'h80, b:8'h01, lo:8'h7F, hi:8'h00, fl:4'b0011, cycles:2});
        vecs.push_back('{op:3'd0, a:8'hFF, b:8'h01, lo:8'h00, hi:8'h00, fl:4'b0110, cycles:2});
        vecs.push_back('{op:3'd2, a:8'hF0, b:8'h3C, lo:8'h30, hi:8'h00, fl:4'b0000, cycles:2});
        vecs.push_back('{op:3'd3, a:8'h00, b:8'h00, lo:8'h00, hi:8'h00, fl:4'b0100, cycles:2});
        vecs.push_back('{op:3'd4, a:8'hAA, b:8'h55, lo:8'hFF, hi:8'h00, fl:4'b1000, cycles:2});
        vecs.push_back('{op:3'd5, a:8'h0F, b:8'h00, lo:8'hF0, hi:8'h00, fl:4'b1000, cycles:2});
        vecs.push_back('{op:3'd7, a:8'h03, b:8'h09, lo:8'h03, hi:8'h00, fl:4'b1000, cycles:2});
`ifdef SEQ_MUL_EN
        vecs.push_back('{op:3'd6, a:8'hFF, b:8'hFF, lo:8'h01, hi:8'hFE, fl:4'b1010, cycles:9});
        vecs.push_back('{op:3'd6, a:8'h00, b:8'h37, lo:8'h00, hi:8'h00, fl:4'b0100, cycles:9});
        vecs.push_back('{op:3'd6, a:8'h0D, b:8'h0B, lo:8'h8F, hi:8'h00, fl:4'b0000, cycles:9});
`else
        vecs.push_back('{op:3'd6, a:8'hFF, b:8'hFF, lo:8'h00, hi:8'h00, fl:4'b0100, cycles:2});
`endif

        // Reset then idle
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready",  {31'h0, req_ready},  32'd1);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
        check("rst_flags",      {28'h0, flags},      32'd0);
        check("rst_alu_op",     {29'h0, alu_op},     32'd0);
        check("rst_resp",       {16'h0, resp_hi, resp_lo}, 32'd0);
        check("rst_alu_ab",     {16'h0, alu_a, alu_b},     32'd0);

        // Directed vectors
        foreach (vecs[i]) run_and_check($sformatf("vec%0d", i), vecs[i]);

        // Flags persist across idle cycles
        last_fl = vecs[vecs.size()-1].fl;
        repeat (4) @(negedge clk);
        check("idle_flags_hold", {28'h0, flags}, {28'h0, last_fl});
        check("idle_alu_op",     {29'h0, alu_op}, 32'd0);

        // Backpressure: response held, second request held on req_valid
        resp_ready = 1'b0;
        @(negedge clk);
        req_op = 3'd0; req_a = 8'h10; req_b = 8'h20; req_valid = 1'b1;
        @(posedge clk);
        #1 req_op = 3'd4; req_a = 8'hAA; req_b = 8'h0F;
        wait_resp(edges);
        check("bp_first_cycles", edges + 1, 32'd2);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_hold_valid%0d", k), {31'h0, resp_valid}, 32'd1);
            check($sformatf("bp_hold_lo%0d", k),    {24'h0, resp_lo},    32'h30);
            check($sformatf("bp_no_ready%0d", k),   {31'h0, req_ready},  32'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp_after_hs_ready", {31'h0, req_ready},  32'd1);
        check("bp_after_hs_valid", {31'h0, resp_valid}, 32'd0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_resp(edges);
        check("bp_second_lo",     {24'h0, resp_lo}, 32'hA5);
        check("bp_second_flags",  {28'h0, flags},   32'b1000);
        check("bp_second_cycles", edges + 1,        32'd2);
        @(posedge clk);

        // Reset while an operation is in flight (mid-MUL, or pending response)
        resp_ready = 1'b0;
        @(negedge clk);
`ifdef SEQ_MUL_EN
        req_op = 3'd6; req_a = 8'hFF; req_b = 8'hFF;
`else
        req_op = 3'd0; req_a = 8'h7F; req_b = 8'h01;
`endif
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_resp_valid", {31'h0, resp_valid}, 32'd0);
        check("midrst_req_ready",  {31'h0, req_ready},  32'd1);
        check("midrst_flags",      {28'h0, flags},      32'd0);
        check("midrst_alu_op",     {29'h0, alu_op},     32'd0);
        repeat (3) @(negedge clk);
        check("midrst_stays_idle", {31'h0, resp_valid}, 32'd0);
        run_and_check("post_rst_add", ref_model(3'd0, 8'h02, 8'h03));
        check("post_rst_add_value", {24'h0, resp_lo}, 32'h05);

        // Randomized operations against the reference model
        for (int n = 0; n < 200; n++) begin
            logic [2:0] op;
            logic [7:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = 8'($urandom);
            b  = 8'($urandom);
            if (n % 16 == 0) a = 8'h00;
            if (n % 16 == 1) b = 8'hFF;
            run_and_check($sformatf("rnd%0d_op%0d_%02h_%02h", n, op, a, b), ref_model(op, a, b));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
